y_latch_monitor: RTL
====================

# y_latch_monitor

Downstream monitor for the single-bit feedback-latch output Y. It synchronises the asynchronous Y level into the clock domain and counts its rising and falling edges. It measures the width of each complete high pulse in clock cycles and hands each width to a consumer over a valid/ready port. It sits between the latch stage and the test/debug logic that logs its behaviour.

## Interface
- CNT_W, 8: width of the edge counters.
- LEN_W, 16: width of the pulse-length measurement.

- clk  in  1  single system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- y_in  in  1  latch output Y; asynchronous to clk.
- clr  in  1  synchronous clear of counters, flags and report slot.
- pulse_ready  in  1  consumer accepts pulse_len this cycle.
- y_sync  out  1  synchronised Y level (second synchroniser flop).
- rise_cnt  out  CNT_W  rising edges seen, saturating.
- fall_cnt  out  CNT_W  falling edges seen, saturating.
- pulse_len  out  LEN_W  width of last reported high pulse, in cycles.
- pulse_valid  out  1  pulse_len holds an unconsumed value.
- overrun  out  1  sticky: a pulse was dropped because the slot was full.

## Operation
- Synchroniser: y_in feeds flops s1 and s2 (y_sync = s2). A third flop y_d holds the previous y_sync.
  - s1, s2 and y_d reset to 1, matching the latch's power-up value of 1, so no spurious edge occurs after reset.
- Edge detect: rise = y_sync & ~y_d; fall = ~y_sync & y_d.
- State machine, reset state S_INIT:
  - S_INIT (high level seen without an observed rise):
    - fall → S_LOW, fall_cnt++, nothing reported.
    - rise (y went 1→0→1 before y_d sampled low is impossible) is not applicable.
  - S_LOW:
    - rise → S_HIGH, rise_cnt++, width loaded with 1.
  - S_HIGH:
    - While y_sync & y_d: width increments, saturating at 2^LEN_W−1.
    - fall → S_LOW, fall_cnt++, width offered to the report slot.
- Report slot:
  - Slot empty: pulse_len ← width, pulse_valid ← 1.
  - Slot full, pulse_ready=0: new width is dropped, overrun ← 1, pulse_len keeps the old value.
  - Slot full, pulse_ready=1 in the same cycle as the offer: old value is consumed, the new value is loaded, pulse_valid stays 1, no overrun.
  - pulse_ready=1 with no offer: pulse_valid ← 0; pulse_len holds its value.
  - pulse_ready while pulse_valid=0 is ignored.
- Counters: rise_cnt and fall_cnt saturate at 2^CNT_W−1 and never wrap.
- clr, synchronous, priority over all events in the same cycle (that cycle's edge is not counted or reported):
  - Clears rise_cnt, fall_cnt, width, pulse_len, pulse_valid and overrun.
  - State ← S_INIT if y_sync=1, else S_LOW.
  - Synchroniser flops are untouched.
- Reset values: y_sync=1, rise_cnt=0, fall_cnt=0, pulse_len=0, pulse_valid=0, overrun=0, state=S_INIT.
  - Reset mid-pulse discards the measurement; the next falling edge is not reported.

## Timing
- y_in changes before clk edge k → s1 updates at k, y_sync updates at k+1.
- Edge-derived updates (counters, state, pulse_valid, pulse_len, overrun) are visible after edge k+2.
- Latency from y_in edge to counter/valid update: 3 clocks.
- Pulse width: y_sync high for exactly N cycles → pulse_len = N (saturated). The minimum reportable pulse is N=1.
- y_in pulses shorter than one clock period may be missed. This is permitted; no count is required for them.
- pulse_valid stays asserted and pulse_len stays stable until the cycle pulse_ready=1.
- Consumer transfer occurs on the clk edge where pulse_valid & pulse_ready.

## Test plan
- Reset with y_in=1, hold 10 cycles → y_sync=1, rise_cnt=0, fall_cnt=0, pulse_valid=0. Then y_in→0 → fall_cnt=1 after 3 clocks, no report.
- From S_LOW, y_in high for exactly 5 clocks (synchronous stimulus) → rise_cnt=1, fall_cnt=1, pulse_len=5, pulse_valid=1. pulse_ready pulsed for 1 cycle → pulse_valid=0.
- Two pulses (widths 3 and 7) with pulse_ready held 0 → pulse_len=3, pulse_valid=1, overrun=1. Then pulse_ready=1 → pulse_valid=0.
- Fall offer coincident with pulse_ready=1 while slot full (widths 4 then 6) → pulse_len=6, pulse_valid=1, overrun=0.
- 260 pulses with CNT_W=8 → rise_cnt=255 and fall_cnt=255 (saturated). Then clr → all counts 0, overrun=0, pulse_valid=0.
- rst_n asserted mid-pulse (y high 4 cycles), released with y_in=1, then y_in→0 → no report, fall_cnt=1. Width saturates at 65535 for a 70000-cycle pulse.

Source files
------------

// File: rtl/y_latch_monitor_if.sv
// Pulse-width report port: the monitor offers a width, the consumer accepts it.
interface y_latch_monitor_if #(
    parameter int unsigned LEN_W = 16
);
    logic [LEN_W-1:0] pulse_len;
    logic             pulse_valid;
    logic             pulse_ready;

    modport master (
        output pulse_len,
        output pulse_valid,
        input  pulse_ready
    );

    modport slave (
        input  pulse_len,
        input  pulse_valid,
        output pulse_ready
    );
endinterface

// File: rtl/y_latch_monitor.sv
// Synchronises the asynchronous latch output Y, counts its edges and reports
// the width of each complete high pulse over a single-slot valid/ready port.
module y_latch_monitor #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned LEN_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               y_in,
    input  logic               clr,
    output logic               y_sync,
    output logic [CNT_W-1:0]   rise_cnt,
    output logic [CNT_W-1:0]   fall_cnt,
    output logic               overrun,
    y_latch_monitor_if.master  pulse
);

    typedef enum logic [1:0] {
        S_INIT,
        S_LOW,
        S_HIGH
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [LEN_W-1:0] LEN_MAX = '1;

    state_t           state;
    logic             s1;
    logic             y_d;
    logic             rise;
    logic             fall;
    logic [LEN_W-1:0] width;

    // Flops preset to 1 to match the latch power-up level: no edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1     <= 1'b1;
            y_sync <= 1'b1;
            y_d    <= 1'b1;
        end else begin
            s1     <= y_in;
            y_sync <= s1;
            y_d    <= y_sync;
        end
    end

    assign rise = y_sync & ~y_d;
    assign fall = ~y_sync & y_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= S_INIT;
            rise_cnt          <= '0;
            fall_cnt          <= '0;
            width             <= '0;
            overrun           <= 1'b0;
            pulse.pulse_len   <= '0;
            pulse.pulse_valid <= 1'b0;
        end else if (clr) begin
            state             <= y_sync ? S_INIT : S_LOW;
            rise_cnt          <= '0;
            fall_cnt          <= '0;
            width             <= '0;
            overrun           <= 1'b0;
            pulse.pulse_len   <= '0;
            pulse.pulse_valid <= 1'b0;
        end else begin
            // A consume frees the slot; a same-cycle offer below refills it.
            if (pulse.pulse_valid && pulse.pulse_ready) begin
                pulse.pulse_valid <= 1'b0;
            end
            case (state)
                S_INIT: begin
                    if (fall) begin
                        state <= S_LOW;
                        if (fall_cnt != CNT_MAX) fall_cnt <= fall_cnt + CNT_W'(1);
                    end
                end
                S_LOW: begin
                    if (rise) begin
                        state <= S_HIGH;
                        width <= LEN_W'(1);
                        if (rise_cnt != CNT_MAX) rise_cnt <= rise_cnt + CNT_W'(1);
                    end
                end
                S_HIGH: begin
                    if (fall) begin
                        state <= S_LOW;
                        if (fall_cnt != CNT_MAX) fall_cnt <= fall_cnt + CNT_W'(1);
                        if (!pulse.pulse_valid || pulse.pulse_ready) begin
                            pulse.pulse_len   <= width;
                            pulse.pulse_valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end else if (y_sync && y_d && width != LEN_MAX) begin
                        width <= width + LEN_W'(1);
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

endmodule
